// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin shared 16-bit LFSR with masked rejection sampling per requester.
// Define RNG_STATS_EN to add saturating reject_cnt/grant_cnt outputs.
module rng_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LIM_W = 8,
  parameter int MAX_TRY = 8,
  parameter logic [15:0] SEED_RST = 16'hDA49
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LIM_W-1:0] req_limit,
  input  logic                     seed_valid,
  input  logic [15:0]              seed,
  output logic [NUM_REQ-1:0]       ack,
  output logic [LIM_W-1:0]         rand_out,
  output logic                     busy
`ifdef RNG_STATS_EN
  ,
  output logic [15:0]              reject_cnt,
  output logic [15:0]              grant_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(MAX_TRY) + 1;
  typedef enum logic [1:0] {IDLE, DRAW, ACK} state_t;
  state_t state, state_nx;
  logic [15:0] lfsr;
  logic [PW-1:0] ptr, idx, gnt;
  logic [LIM_W-1:0] lim, mask, lim_in, mask_nx, cand;
  logic [TW-1:0] try_cnt;
  logic [2*NUM_REQ-1:0] rot;
  logic hit, accept, last;
  int off, sum;
  // Rotate requests so offset 0 is ptr; lowest set offset wins.
  always_comb begin
    rot = {req, req} >> ptr;
    off = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? i : off;
    sum = int'(ptr) + off;
    gnt = PW'(sum >= NUM_REQ ? sum - NUM_REQ : sum);
    lim_in = req_limit[gnt*LIM_W +: LIM_W];
    mask_nx = lim_in - LIM_W'(1);
    for (int i = 1; i < LIM_W; i++) mask_nx = mask_nx | (mask_nx >> i);
  end
  always_comb begin
    cand = lfsr[LIM_W-1:0] & mask;
    hit = req[idx];
    accept = lim == '0 || cand < lim;
    last = try_cnt == TW'(MAX_TRY - 1);
    state_nx = state;
    state_nx = state == IDLE ? (|req ? DRAW : IDLE) :
               state == DRAW ? (!hit ? IDLE : (accept || last) ? ACK : DRAW) : IDLE;
    ack = state == ACK ? NUM_REQ'(1) << idx : '0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED_RST;
      ptr <= '0;
      idx <= '0;
      lim <= '0;
      mask <= '0;
      try_cnt <= '0;
      rand_out <= '0;
    end else begin
      lfsr <= seed_valid ? (seed == 16'h0 ? SEED_RST : seed) : {lfsr[14:0], lfsr[15] ^ lfsr[13]};
      if (state == IDLE && |req) begin
        idx <= gnt;
        lim <= lim_in;
        mask <= mask_nx;
        try_cnt <= '0;
      end
      // mask < 2*lim, so cand-lim is always in range on fallback.
      if (state == DRAW && hit) begin
        if (accept) rand_out <= cand;
        else if (last) rand_out <= cand - lim;
        else try_cnt <= try_cnt + TW'(1);
      end
      if (state == ACK) ptr <= PW'((int'(idx) + 1) % NUM_REQ);
    end
  end
`ifdef RNG_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      reject_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if (state == DRAW && hit && !accept && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
      if (state == ACK && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: randomized self-checking bench with a transaction-level draw model.
module tb_rng_arbiter;
  logic clk = 0, rst = 1;
  logic [3:0] req = 0;
  logic [31:0] req_limit = 0;
  logic seed_valid = 0;
  logic [15:0] seed = 0;
  logic [3:0] ack, ack1;
  logic [7:0] rand_out, rand1;
  logic busy, busy1;
`ifdef RNG_STATS_EN
  logic [15:0] rej, gcnt, rej1, gcnt1;
`endif
  int checks = 0, errors = 0, mptr = 0;
  logic [15:0] mlfsr = 16'hDA49;

  always #5 clk = ~clk;

  rng_arbiter dut (.clk(clk), .rst(rst), .req(req), .req_limit(req_limit),
    .seed_valid(seed_valid), .seed(seed), .ack(ack), .rand_out(rand_out), .busy(busy)
`ifdef RNG_STATS_EN
    , .reject_cnt(rej), .grant_cnt(gcnt)
`endif
  );
  rng_arbiter #(.MAX_TRY(1)) dut1 (.clk(clk), .rst(rst), .req(req), .req_limit(req_limit),
    .seed_valid(seed_valid), .seed(seed), .ack(ack1), .rand_out(rand1), .busy(busy1)
`ifdef RNG_STATS_EN
    , .reject_cnt(rej1), .grant_cnt(gcnt1)
`endif
  );

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13]};
  endfunction

  function automatic int pick(input logic [3:0] r, input int p);
    for (int o = 0; o < 4; o++) if (r[(p + o) % 4]) return (p + o) % 4;
    return -1;
  endfunction

  // Draw outcome from the LFSR value seen at DRAW entry: number of draws and result.
  task automatic predict(input logic [15:0] l0, input int lim, input int max_try,
                         output int draws, output logic [7:0] val);
    int m, c;
    logic [15:0] l;
    m = 255;
    if (lim != 0) begin
      m = 0;
      while (m < lim - 1) m = 2 * m + 1;
    end
    l = l0;
    draws = max_try;
    val = 0;
    for (int t = 1; t <= max_try; t++) begin
      c = int'(l[7:0]) & m;
      if (lim == 0 || c < lim) begin
        draws = t;
        val = 8'(c);
        return;
      end
      if (t == max_try) begin
        val = 8'(c - lim);
        return;
      end
      l = step(l);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mlfsr = rst ? 16'hDA49 : seed_valid ? (seed == 0 ? 16'hDA49 : seed) : step(mlfsr);
    if (rst) mptr = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  task automatic run_grant(input bit perturb, output logic [3:0] seen);
    int e, d;
    logic [7:0] v;
    e = pick(req, mptr);
    cyc();
    seed_valid = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL grant_busy got %b exp 1", busy); end
    predict(mlfsr, int'(req_limit[e*8 +: 8]), 8, d, v);
    if (perturb) req_limit = $urandom;
    for (int i = 1; i < d; i++) begin
      cyc();
      checks++;
      if (ack !== 4'b0) begin errors++; $display("FAIL grant_early_ack got %b exp 0000", ack); end
    end
    cyc();
    seen = ack;
    checks++;
    if (ack !== 4'(1 << e)) begin errors++; $display("FAIL grant_ack got %b exp %b", ack, 4'(1 << e)); end
    checks++;
    if (rand_out !== v) begin errors++; $display("FAIL grant_rand got %h exp %h", rand_out, v); end
    mptr = (e + 1) % 4;
    cyc();
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL grant_idle got busy=%b ack=%b exp 0 0000", busy, ack); end
  endtask

  task automatic test_reset();
    req = 4'b0001;
    req_limit = 0;
    rst = 1;
    cyc();
    cyc();
    checks++;
    if (ack !== 4'b0 || rand_out !== 8'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got ack=%b rand=%h busy=%b exp 0000 00 0", ack, rand_out, busy);
    end
    checks++;
    if (dut.lfsr !== 16'hDA49) begin errors++; $display("FAIL reset_lfsr got %h exp da49", dut.lfsr); end
  endtask

  task automatic test_full_range();
    rst = 0;
    cyc();
    checks++;
    if (dut.lfsr !== 16'hB493 || busy !== 1'b1) begin
      errors++; $display("FAIL full_draw_entry got lfsr=%h busy=%b exp b493 1", dut.lfsr, busy);
    end
    cyc();
    checks++;
    if (ack !== 4'b0001 || rand_out !== 8'h93) begin
      errors++; $display("FAIL full_ack got ack=%b rand=%h exp 0001 93", ack, rand_out);
    end
    req = 0;
    cyc();
    mptr = 1;
  endtask

  task automatic test_reject();
    req = 4'b0001;
    req_limit = 32'h3;
    do_reset();
    cyc();
    cyc();
    checks++;
    if (ack !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL reject_wait got ack=%b busy=%b exp 0000 1", ack, busy); end
    cyc();
    checks++;
    if (ack !== 4'b0001 || rand_out !== 8'h02) begin
      errors++; $display("FAIL reject_ack got ack=%b rand=%h exp 0001 02", ack, rand_out);
    end
`ifdef RNG_STATS_EN
    checks++;
    if (rej !== 16'd1) begin errors++; $display("FAIL reject_cnt got %0d exp 1", rej); end
`endif
    req = 0;
    cyc();
`ifdef RNG_STATS_EN
    checks++;
    if (gcnt !== 16'd1) begin errors++; $display("FAIL grant_cnt got %0d exp 1", gcnt); end
`endif
  endtask

  task automatic test_fallback();
    req = 4'b0001;
    req_limit = 32'h3;
    do_reset();
    cyc();
    cyc();
    checks++;
    if (ack1 !== 4'b0001 || rand1 !== 8'h00) begin
      errors++; $display("FAIL fallback_ack got ack=%b rand=%h exp 0001 00", ack1, rand1);
    end
    req = 0;
    cyc();
    cyc();
  endtask

  task automatic test_seed();
    req = 0;
    do_reset();
    seed_valid = 1;
    seed = 16'h0000;
    cyc();
    checks++;
    if (dut.lfsr !== 16'hDA49) begin errors++; $display("FAIL seed_zero got %h exp da49", dut.lfsr); end
    seed = 16'h0001;
    cyc();
    checks++;
    if (dut.lfsr !== 16'h0001) begin errors++; $display("FAIL seed_one got %h exp 0001", dut.lfsr); end
    seed_valid = 0;
    cyc();
    checks++;
    if (dut.lfsr !== 16'h0002) begin errors++; $display("FAIL seed_step got %h exp 0002", dut.lfsr); end
  endtask

  task automatic test_round_robin();
    logic [3:0] seen;
    logic [3:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_b [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0100};
    req = 0;
    req_limit = 0;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_grant(0, seen);
      checks++;
      if (seen !== exp_a[k]) begin errors++; $display("FAIL rr_seq%0d got %b exp %b", k, seen, exp_a[k]); end
      if (k == 1) req = 4'b1101;
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        req = 4'b1111;
        run_grant(0, seen);
        req = 4'b1101;
        checks++;
        if (seen !== 4'b0010) begin errors++; $display("FAIL rr_pre got %b exp 0010", seen); end
      end
      run_grant(0, seen);
      checks++;
      if (seen !== exp_b[k]) begin errors++; $display("FAIL rr_drop%0d got %b exp %b", k, seen, exp_b[k]); end
    end
    req = 0;
  endtask

  task automatic test_abort();
    logic [3:0] seen;
    req = 4'b0001;
    req_limit = 0;
    do_reset();
    cyc();
    req = 0;
    cyc();
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL abort_idle got busy=%b ack=%b exp 0 0000", busy, ack); end
    req = 4'b0011;
    run_grant(0, seen);
    checks++;
    if (seen !== 4'b0001) begin errors++; $display("FAIL abort_ptr got %b exp 0001", seen); end
    cyc();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_draw got %b exp 1", busy); end
    rst = 1;
    cyc();
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0 || rand_out !== 8'h0 || dut.lfsr !== 16'hDA49) begin
      errors++; $display("FAIL abort_reset got busy=%b ack=%b rand=%h lfsr=%h exp 0 0000 00 da49", busy, ack, rand_out, dut.lfsr);
    end
    rst = 0;
    req = 0;
    cyc();
  endtask

  task automatic test_random();
    logic [3:0] seen;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      req = 4'($urandom_range(0, 15));
      for (int s = 0; s < 4; s++)
        req_limit[s*8 +: 8] = $urandom_range(0, 3) == 0 ? 8'h0 : 8'($urandom_range(1, 40));
      seed_valid = $urandom_range(0, 3) == 0;
      seed = $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom);
      if (req == 0) begin
        cyc();
        seed_valid = 0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle got %b exp 0", busy); end
      end else run_grant(1, seen);
    end
    req = 0;
  endtask

  initial begin
    test_reset();
    test_full_range();
    test_reject();
    test_fallback();
    test_seed();
    test_round_robin();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
Shared random-number service for the game logic. Owns a 16-bit Fibonacci LFSR (taps 15 and 13, shift-left, feedback into bit 0) and shares it among NUM_REQ requesters using round-robin arbitration. Each requester asks for a value in [0, limit). The block reduces the LFSR output to that range by masked rejection sampling and returns the result with a one-cycle ack pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LIM_W, 8, width of limit and result
MAX_TRY, 8, maximum draws per grant before deterministic fallback (>=1)
SEED_RST, 16'hDA49, LFSR value loaded on reset and used in place of an all-zero seed

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  level request per requester; held until ack
req_limit  in  NUM_REQ*LIM_W  per-requester range limit; slice i = bits [i*LIM_W +: LIM_W]; 0 means full range 2^LIM_W
seed_valid  in  1  load seed into the LFSR this cycle
seed  in  16  seed value
ack  out  NUM_REQ  one-hot, one-cycle pulse; result valid in that cycle
rand_out  out  LIM_W  result; holds its value until the next ack
busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset values: lfsr=SEED_RST, state=IDLE, ptr=0, ack=0, rand_out=0, try_cnt=0.
- LFSR update priority each cycle: rst > seed_valid > step.
  - Step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]}. The LFSR steps every cycle, including IDLE (free-running).
  - Seed: lfsr <= (seed==0) ? SEED_RST : seed. Seeding is accepted in any state; an in-flight draw continues on the new state.
- IDLE state:
  - If req != 0, grant idx = first set bit at or after ptr, scanning upward and wrapping.
  - Latch idx and lim = req_limit slice.
  - Compute mask = smallest 2^k-1 with mask >= lim-1. lim=0 gives all-ones; lim=1 gives 0.
  - Clear try_cnt and go to DRAW.
- DRAW state:
  - If req[idx]==0 (request withdrawn), go to IDLE. No ack is issued and ptr is unchanged.
  - Otherwise cand = lfsr[LIM_W-1:0] & mask, sampled from the current register value.
  - Accept when lim==0 or cand < lim: rand_out <= cand, go to ACK.
  - Reject otherwise:
    - If try_cnt == MAX_TRY-1, rand_out <= cand-lim (always < lim because mask < 2*lim), go to ACK.
    - Else try_cnt++ and stay in DRAW.
- ACK state: ack[idx]=1 for exactly this cycle, ptr <= (idx+1) mod NUM_REQ, go to IDLE.
- Latency:
  - Request seen in IDLE at edge N: DRAW is entered at N+1 and ack is asserted after edge N+2 at the earliest.
  - Each rejection adds 1 cycle. The worst case is MAX_TRY+2 cycles.
- Back-to-back: at least one IDLE cycle separates grants, so the same requester receives a new ack no sooner than 3 cycles after the previous one.
- Limit changes after grant are ignored; the latched lim is used.
- Reset asserted mid-operation: return to IDLE immediately and restore all reset values; any pending ack is lost.
- busy = (state != IDLE).

Optional Feature:
RNG_STATS_EN
- Defined: adds output reject_cnt [15:0], reset 0, incremented on every rejected candidate (including the fallback draw) and saturating at 16'hFFFF. Also adds output grant_cnt [15:0], incremented on every ack and saturating.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

Test Plan:
1. Full-range draw: req=4'b0001 and limit0=0 held through reset release -> first edge with rst low: lfsr=16'hB493, DRAW entered; second edge: ack=4'b0001, rand_out=8'h93.
2. Rejection: same as test 1 but limit0=3 (mask 3) -> cand 3 rejected; next lfsr 16'h6926 gives cand 2; ack[0] one cycle later than test 1 with rand_out=2; reject_cnt=1 if RNG_STATS_EN is defined.
3. Fallback: MAX_TRY=1, limit0=3, same start as test 1 -> cand 3 >= 3, rand_out=0, ack on the same cycle as test 1.
4. Round-robin: req=4'b1111, all limits 0, held -> ack sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart. Dropping req[1] after its ack -> sequence continues 0100, 1000, 0001, 0100.
5. Seeding: seed_valid=1 with seed=16'h0000 in IDLE -> next cycle lfsr=16'hDA49. With seed=16'h0001 -> lfsr=16'h0001, then 16'h0002 on the following step.
6. Abort and reset: drop req[0] while in DRAW -> no ack, busy falls next cycle, ptr unchanged. Assert rst during DRAW -> next cycle state=IDLE, ack=0, rand_out=0, lfsr=16'hDA49.
